// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target receiver.
// The default address is also used by the spitoi2c benches so both ends agree.
package i2c_pkg;

    // Protocol phase of the target FSM
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } i2c_state_t;

    // Bits per byte on the bus (address+R/W or data)
    localparam int I2C_BITS = 8;

    // Target address shared by the receiver and the bridge benches
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one asynchronous I2C line into the clk domain and
// reports its level plus single-cycle rise/fall events.
// Optional feature: define I2C_RX_FILTER_EN to add a 3-sample stable filter
// behind the synchronizer (rejects glitches of up to 2 clk cycles).
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // Two-flop synchronizer; resets to 1 because an idle I2C line is high.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source and the chain really delays by one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

`ifdef I2C_RX_FILTER_EN
    logic r_hist1;
    logic r_hist2;

    // Sample history for the stability filter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist1 <= 1'b1;
            r_hist2 <= 1'b1;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    // Accept a new level only once three consecutive samples agree
    always_comb begin
        w_level = r_prev;
        if ((r_sync2 == r_hist1) && (r_hist1 == r_hist2)) begin
            w_level = r_sync2;
        end
    end
`else
    assign w_level = r_sync2;
`endif

    // Previous-value register for edge detection (also holds the filtered level)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target. Detects START/STOP, matches a 7-bit
// address, ACKs address and data bytes and strobes each received data byte.
// Optional feature: define I2C_RX_FILTER_EN to enable the glitch filter in
// i2c_line_sync (pin-to-event latency grows from 3 to 5 clk cycles).
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = I2C_DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_pull,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       busy
);

    localparam logic [3:0] LAST_BIT = 4'(I2C_BITS - 1);

    // Synchronized line views and events
    logic w_scl_level;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_level;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;

    // Registered state
    i2c_state_t r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_pull;
    logic [7:0] r_data;
    logic       r_valid;

    // Next-state values
    i2c_state_t w_state_next;
    logic [3:0] w_cnt_next;
    logic [7:0] w_shift_next;
    logic       w_pull_next;
    logic [7:0] w_data_next;
    logic       w_valid_next;
    logic [7:0] w_byte;
    logic       w_last_bit;
    logic       w_addr_match;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (i2c_scl),
        .o_level (w_scl_level),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (i2c_sda),
        .o_level (w_sda_level),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    // Bus conditions: SDA may only move while SCL is high at START/STOP
    assign w_start = w_sda_fall & w_scl_level;
    assign w_stop  = w_sda_rise & w_scl_level;

    // Byte as it will look once the current SDA bit is shifted in (MSB first)
    assign w_byte       = {r_shift[6:0], w_sda_level};
    assign w_last_bit   = (r_cnt == LAST_BIT);
    assign w_addr_match = (w_byte[7:1] == ADDR) && (w_byte[0] == 1'b0);

    // State and datapath registers; reset drops the transfer and releases SDA
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_shift <= 8'h00;
            r_pull  <= 1'b0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_pull  <= w_pull_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
        end
    end

    // Next-state logic: START/STOP override any SCL edge seen in the same cycle
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_pull_next  = r_pull;
        w_data_next  = r_data;
        w_valid_next = 1'b0;

        if (w_stop) begin
            // Partial byte is dropped; no strobe
            w_state_next = S_IDLE;
            w_cnt_next   = 4'd0;
            w_pull_next  = 1'b0;
        end else if (w_start) begin
            // First or repeated START: always restart address reception
            w_state_next = S_ADDR;
            w_cnt_next   = 4'd0;
            w_pull_next  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (w_last_bit) begin
                            w_cnt_next   = 4'd0;
                            // Reads are never acknowledged
                            w_state_next = w_addr_match ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end

                S_ADDR_ACK, S_DATA_ACK: begin
                    // First SCL fall: pull SDA for the 9th clock.
                    // Second SCL fall: release and start the next byte.
                    if (w_scl_fall) begin
                        if (!r_pull) begin
                            w_pull_next = 1'b1;
                        end else begin
                            w_pull_next  = 1'b0;
                            w_state_next = S_DATA;
                            w_cnt_next   = 4'd0;
                        end
                    end
                end

                S_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (w_last_bit) begin
                            w_cnt_next   = 4'd0;
                            w_data_next  = w_byte;
                            w_valid_next = 1'b1;
                            w_state_next = S_DATA_ACK;
                        end
                    end
                end

                S_IGNORE: begin
                    w_pull_next = 1'b0;
                end

                default: begin
                    w_pull_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_pull   = r_pull;
    assign data       = r_data;
    assign data_valid = r_valid;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: drives I2C write transfers into i2c_target_rx as a bus
// controller, checks ACK behaviour inline and received bytes via a queue.
`timescale 1ns/1ps
module tb_i2c_target_rx;

    localparam int P = 10;  // clk cycles per SCL phase

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       w_sda_line;
    logic       sda_pull;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int pull_cnt = 0;
    int busy_low_cnt = 0;
    logic prev_dv = 1'b0;
    logic [7:0] exp_q[$];

    // Open-drain bus: target pulling wins over the controller's released 1
    assign w_sda_line = m_sda & ~sda_pull;

    always #10 clk = ~clk;

    i2c_target_rx #(.ADDR(7'h50)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (m_scl),
        .i2c_sda    (w_sda_line),
        .sda_pull   (sda_pull),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy)
    );

    // One clk step sampled on the falling edge; pops the scoreboard on strobes
    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        if (sda_pull === 1'b1) pull_cnt++;
        if (busy === 1'b0) busy_low_cnt++;
        if (data_valid === 1'b1) begin
            tests_run++;
            if (prev_dv === 1'b1) begin
                tests_failed++;
                $display("FAIL strobe_width: data_valid high on consecutive cycles, data=%h", data);
            end else if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe: got data=%h, expected no strobe", data);
            end else begin
                exp = exp_q.pop_front();
                if (data !== exp) begin
                    tests_failed++;
                    $display("FAIL rx_byte: got %h expected %h", data, exp);
                end
            end
        end
        prev_dv = data_valid;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_start();
        m_sda = 1'b0;
        wait_clk(P);
        m_scl = 1'b0;
        wait_clk(P);
    endtask

    task automatic bus_rep_start();
        wait_clk(2);
        m_sda = 1'b1;
        wait_clk(P - 2);
        m_scl = 1'b1;
        wait_clk(P);
        m_sda = 1'b0;
        wait_clk(P);
        m_scl = 1'b0;
        wait_clk(P);
    endtask

    task automatic bus_stop();
        wait_clk(2);
        m_sda = 1'b0;
        wait_clk(P - 2);
        m_scl = 1'b1;
        wait_clk(P);
        m_sda = 1'b1;
        wait_clk(P);
    endtask

    // One SCL pulse; returns resolved SDA and sda_pull sampled mid-high
    task automatic bus_bit(input logic b, output logic line, output logic pull);
        wait_clk(2);
        m_sda = b;
        wait_clk(P - 2);
        m_scl = 1'b1;
        wait_clk(P / 2);
        line = w_sda_line;
        pull = sda_pull;
        wait_clk(P / 2);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic l, p;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], l, p);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        tick();
        tests_run += 4;
        if (sda_pull !== 1'b0) begin tests_failed++; $display("FAIL reset_pull: got %b expected 0", sda_pull); end
        if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", data); end
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_byte();
        logic l, p;
        bus_start();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_start: got %b expected 1", busy); end
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b1 || l !== 1'b0) begin tests_failed++; $display("FAIL wr_addr_ack: got pull=%b sda=%b expected pull=1 sda=0", p, l); end
        exp_q.push_back(8'hAA);
        send_byte(8'hAA);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b1 || l !== 1'b0) begin tests_failed++; $display("FAIL wr_data_ack: got pull=%b sda=%b expected pull=1 sda=0", p, l); end
        bus_stop();
        wait_clk(P);
        tests_run += 3;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL wr_missing: got %0d pending bytes expected 0", exp_q.size()); exp_q.delete(); end
        if (data !== 8'hAA) begin tests_failed++; $display("FAIL wr_data_hold: got %h expected aa", data); end
    endtask

    task automatic test_wrong_addr();
        logic l, p;
        int pull_before;
        pull_before = pull_cnt;
        bus_start();
        send_byte(8'hA2);  // 0x51 + W
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b0 || l !== 1'b1) begin tests_failed++; $display("FAIL wa_nack: got pull=%b sda=%b expected pull=0 sda=1", p, l); end
        send_byte(8'h5A);
        bus_bit(1'b1, l, p);
        bus_stop();
        wait_clk(P);
        tests_run += 2;
        if (pull_cnt != pull_before) begin tests_failed++; $display("FAIL wa_pull_seen: got %0d pull cycles expected 0", pull_cnt - pull_before); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL wa_busy: got %b expected 0", busy); end
    endtask

    task automatic test_read_addr();
        logic l, p;
        bus_start();
        send_byte(8'hA1);  // 0x50 + R
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b0) begin tests_failed++; $display("FAIL rd_nack: got pull=%b expected 0", p); end
        send_byte(8'h33);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b0) begin tests_failed++; $display("FAIL rd_ignore_ack: got pull=%b expected 0", p); end
        bus_rep_start();
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b1) begin tests_failed++; $display("FAIL rd_restart_ack: got pull=%b expected 1", p); end
        exp_q.push_back(8'h55);
        send_byte(8'h55);
        bus_bit(1'b1, l, p);
        bus_stop();
        wait_clk(P);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rd_missing: got %0d pending bytes expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_partial_byte();
        logic l, p;
        bus_start();
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        bus_bit(1'b1, l, p);
        bus_bit(1'b0, l, p);
        bus_bit(1'b1, l, p);
        bus_bit(1'b1, l, p);
        bus_stop();
        wait_clk(P);
        tests_run += 2;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL part_busy: got %b expected 0", busy); end
        if (data !== 8'h55) begin tests_failed++; $display("FAIL part_data: got %h expected 55", data); end
        // A fresh transfer must start cleanly from IDLE
        bus_start();
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b1) begin tests_failed++; $display("FAIL part_next_ack: got pull=%b expected 1", p); end
        bus_stop();
        wait_clk(P);
    endtask

    task automatic test_back_to_back();
        logic l, p;
        int busy_low_before;
        bus_start();
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        bus_bit(1'b1, l, p);
        busy_low_before = busy_low_cnt;
        bus_rep_start();
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b1) begin tests_failed++; $display("FAIL b2b_addr_ack: got pull=%b expected 1", p); end
        exp_q.push_back(8'hC3);
        send_byte(8'hC3);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (busy_low_cnt != busy_low_before) begin tests_failed++; $display("FAIL b2b_busy: got %0d low cycles expected 0", busy_low_cnt - busy_low_before); end
        bus_stop();
        wait_clk(P);
        tests_run += 2;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_missing: got %0d pending bytes expected 0", exp_q.size()); exp_q.delete(); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_reset_during_ack();
        logic l, p;
        bus_start();
        send_byte(8'hA0);
        wait_clk(2);
        m_sda = 1'b1;
        wait_clk(P - 2);
        m_scl = 1'b1;
        wait_clk(P / 2);
        tests_run++;
        if (sda_pull !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_pull: got %b expected 1", sda_pull); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run += 4;
        if (sda_pull !== 1'b0) begin tests_failed++; $display("FAIL rst_pull: got %b expected 0", sda_pull); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (data !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h expected 00", data); end
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", data_valid); end
        wait_clk(P / 2);
        m_scl = 1'b0;
        bus_stop();
        wait_clk(P);
        bus_start();
        send_byte(8'hA0);
        bus_bit(1'b1, l, p);
        tests_run++;
        if (p !== 1'b1) begin tests_failed++; $display("FAIL rst_next_ack: got pull=%b expected 1", p); end
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        bus_bit(1'b1, l, p);
        bus_stop();
        wait_clk(P);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rst_missing: got %0d pending bytes expected 0", exp_q.size()); exp_q.delete(); end
    endtask

`ifdef I2C_RX_FILTER_EN
    task automatic test_glitch();
        m_sda = 1'b0;
        wait_clk(2);
        m_sda = 1'b1;
        wait_clk(2 * P);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_start: got busy=%b expected 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_byte();
        test_wrong_addr();
        test_read_addr();
        test_partial_byte();
        test_back_to_back();
        test_reset_during_ack();
`ifdef I2C_RX_FILTER_EN
        test_glitch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
